// File: rtl/ysyx_bus_rr_arbiter.sv
// N-client single-beat load/store arbiter onto one AXI4 master port.
// One transaction in flight at a time. The grant is round-robin or fixed-priority.
// Store data and strobes are placed on the correct bus lane.
// Load data is picked from the addressed lane.
module ysyx_bus_rr_arbiter #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BUS_W  = 64,
  parameter int unsigned RR     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  // Client side
  input  logic [NUM_M-1:0]             req_valid,
  input  logic [NUM_M-1:0]             req_write,
  input  logic [NUM_M*ADDR_W-1:0]      req_addr,
  input  logic [NUM_M*DATA_W-1:0]      req_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0]  req_wstrb,
  output logic [NUM_M-1:0]             req_ready,
  output logic [NUM_M-1:0]             rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  // AXI4 AR
  output logic                         io_master_arvalid,
  input  logic                         io_master_arready,
  output logic [ADDR_W-1:0]            io_master_araddr,
  output logic [3:0]                   io_master_arid,
  output logic [7:0]                   io_master_arlen,
  output logic [2:0]                   io_master_arsize,
  output logic [1:0]                   io_master_arburst,
  // AXI4 R
  input  logic                         io_master_rvalid,
  output logic                         io_master_rready,
  input  logic [BUS_W-1:0]             io_master_rdata,
  input  logic [1:0]                   io_master_rresp,
  input  logic                         io_master_rlast,
  input  logic [3:0]                   io_master_rid,
  // AXI4 AW
  output logic                         io_master_awvalid,
  input  logic                         io_master_awready,
  output logic [ADDR_W-1:0]            io_master_awaddr,
  output logic [3:0]                   io_master_awid,
  output logic [7:0]                   io_master_awlen,
  output logic [2:0]                   io_master_awsize,
  output logic [1:0]                   io_master_awburst,
  // AXI4 W
  output logic                         io_master_wvalid,
  input  logic                         io_master_wready,
  output logic [BUS_W-1:0]             io_master_wdata,
  output logic [BUS_W/8-1:0]           io_master_wstrb,
  output logic                         io_master_wlast,
  // AXI4 B
  input  logic                         io_master_bvalid,
  output logic                         io_master_bready,
  input  logic [1:0]                   io_master_bresp,
  input  logic [3:0]                   io_master_bid
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LANES  = BUS_W / DATA_W;
  localparam int unsigned IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned SX_W   = STRB_W + 8;

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [NUM_M-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Arbitration and selected request fields
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                hi_found, lo_found;
  logic [IDX_W-1:0]    hi_idx, lo_idx;
  int unsigned         start;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;

  // Lane placement
  logic [ADDR_W-1:0]   off, lane;
  logic [DATA_W-1:0]   wdata_sh;
  logic [STRB_W-1:0]   strb_sh;
  logic [BUS_W/8-1:0]  bus_wstrb;
  logic [DATA_W-1:0]   rd_lane;
  logic [SX_W-1:0]     strb_ext;
  logic [2:0]          size;

  // rid/bid/rlast carry nothing we need with one transaction in flight
  logic unused_inputs;
  assign unused_inputs = ^{io_master_rlast, io_master_rid, io_master_bid};

  // Winner search: first valid at or above the start index, else the lowest valid (wrap)
  always_comb begin
    start     = (RR != 0) ? 32'(ptr_q) : 0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_found  = 1'b0;
    lo_idx    = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!hi_found && req_valid[i] && (i >= start)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (!lo_found && req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Byte offset within a client word, lane within the bus word, and AXI size
  always_comb begin
    off      = addr_q & ADDR_W'(STRB_W - 1);
    lane     = (addr_q >> OFF_W) & ADDR_W'(LANES - 1);
    wdata_sh = wdata_q << {off, 3'b000};
    strb_sh  = wstrb_q << off;
    bus_wstrb = '0;
    rd_lane   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane == ADDR_W'(l)) begin
        bus_wstrb[l*STRB_W +: STRB_W] = strb_sh;
        rd_lane = io_master_rdata[l*DATA_W +: DATA_W];
      end
    end
    strb_ext = SX_W'(wstrb_q);
    case (strb_ext)
      SX_W'(8'h01): size = 3'd0;
      SX_W'(8'h03): size = 3'd1;
      SX_W'(8'h0f): size = 3'd2;
      SX_W'(8'hff): size = 3'd3;
      default:      size = 3'($clog2(STRB_W));
    endcase
  end

  // Transaction FSM next state, request capture and response generation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          for (int unsigned i = 0; i < NUM_M; i++) begin
            if (IDX_W'(i) == win_idx) req_ready[i] = 1'b1;
          end
          gnt_d     = win_idx;
          write_d   = sel_write;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_write ? StWr : StAr;
          if (RR != 0) begin
            ptr_d = (win_idx == IDX_W'(NUM_M - 1)) ? '0 : win_idx + IDX_W'(1);
          end
        end
      end
      StAr: begin
        if (io_master_arready) state_d = StR;
      end
      StR: begin
        if (io_master_rvalid) begin
          for (int unsigned i = 0; i < NUM_M; i++) begin
            if (IDX_W'(i) == gnt_q) rsp_valid_d[i] = 1'b1;
          end
          rsp_rdata_d = rd_lane;
          rsp_err_d   = (io_master_rresp != 2'b00);
          state_d     = StIdle;
        end
      end
      StWr: begin
        aw_done_d = aw_done_q | (io_master_awvalid & io_master_awready);
        w_done_d  = w_done_q | (io_master_wvalid & io_master_wready);
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        if (io_master_bvalid) begin
          for (int unsigned i = 0; i < NUM_M; i++) begin
            if (IDX_W'(i) == gnt_q) rsp_valid_d[i] = 1'b1;
          end
          rsp_rdata_d = '0;
          rsp_err_d   = (io_master_bresp != 2'b00);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign io_master_arvalid = (state_q == StAr);
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = 4'(gnt_q);
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = (state_q == StR);

  assign io_master_awvalid = (state_q == StWr) && !aw_done_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = 4'(gnt_q);
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = (state_q == StWr) && !w_done_q;
  assign io_master_wdata   = {LANES{wdata_sh}};
  assign io_master_wstrb   = bus_wstrb;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state_q == StB);

  // write_q is kept for observability of the captured request type
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_ysyx_bus_rr_arbiter.sv
// Self-checking bench for ysyx_bus_rr_arbiter (NUM_M=2, DATA_W=32, BUS_W=64).
// A table of single transactions, then hand sequences for split AW/W, round-robin
// vs fixed priority, and reset mid-transaction. Responses are checked via a scoreboard.
module tb_ysyx_bus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [63:0] rdata, wdata;

  logic [1:0]  fp_req_ready;
  logic [1:0]  fp_unused_rsp_valid;
  logic [31:0] fp_unused_rsp_rdata, fp_unused_araddr, fp_unused_awaddr;
  logic        fp_unused_rsp_err, fp_unused_arvalid, fp_unused_rready, fp_unused_awvalid;
  logic        fp_unused_wvalid, fp_unused_wlast, fp_unused_bready;
  logic [3:0]  fp_unused_arid, fp_unused_awid;
  logic [7:0]  fp_unused_arlen, fp_unused_awlen, fp_unused_wstrb;
  logic [2:0]  fp_unused_arsize, fp_unused_awsize;
  logic [1:0]  fp_unused_arburst, fp_unused_awburst;
  logic [63:0] fp_unused_wdata;

  always #5 clk = ~clk;

  ysyx_bus_rr_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .BUS_W(64), .RR(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(1'b1), .io_master_rid(4'h0),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
    .io_master_bid(4'h0)
  );

  // Fixed-priority instance behind an always-ready slave, fed the same requests
  ysyx_bus_rr_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .BUS_W(64), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(fp_req_ready),
    .rsp_valid(fp_unused_rsp_valid), .rsp_rdata(fp_unused_rsp_rdata),
    .rsp_err(fp_unused_rsp_err),
    .io_master_arvalid(fp_unused_arvalid), .io_master_arready(1'b1),
    .io_master_araddr(fp_unused_araddr), .io_master_arid(fp_unused_arid),
    .io_master_arlen(fp_unused_arlen), .io_master_arsize(fp_unused_arsize),
    .io_master_arburst(fp_unused_arburst),
    .io_master_rvalid(1'b1), .io_master_rready(fp_unused_rready), .io_master_rdata(64'h0),
    .io_master_rresp(2'b00), .io_master_rlast(1'b1), .io_master_rid(4'h0),
    .io_master_awvalid(fp_unused_awvalid), .io_master_awready(1'b1),
    .io_master_awaddr(fp_unused_awaddr), .io_master_awid(fp_unused_awid),
    .io_master_awlen(fp_unused_awlen), .io_master_awsize(fp_unused_awsize),
    .io_master_awburst(fp_unused_awburst),
    .io_master_wvalid(fp_unused_wvalid), .io_master_wready(1'b1),
    .io_master_wdata(fp_unused_wdata), .io_master_wstrb(fp_unused_wstrb),
    .io_master_wlast(fp_unused_wlast),
    .io_master_bvalid(1'b1), .io_master_bready(fp_unused_bready), .io_master_bresp(2'b00),
    .io_master_bid(4'h0)
  );

  typedef struct {
    int unsigned client;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [63:0] slave_rdata;
    logic [1:0]  resp;
    logic [2:0]  exp_size;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic clear_slave();
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
  endtask

  task automatic set_req(input int unsigned c, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[c] = 1'b1;
    req_write[c] = w;
    req_addr[c*32 +: 32]  = a;
    req_wdata[c*32 +: 32] = d;
    req_wstrb[c*4 +: 4]   = s;
  endtask

  // Scoreboard: every rsp_valid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, want none", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid_client", 64'(rsp_valid), 64'(mon_e.onehot));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  // Zero-wait slave transaction driven from one table record
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    exp_t e;
    oh = 2'b01 << v.client;
    step();
    set_req(v.client, v.write, v.addr, v.wd, v.ws);
    #1;
    check($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'(oh));
    e.onehot = oh;
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    sb.push_back(e);
    step();
    clear_req();
    #1;
    if (!v.write) begin
      check($sformatf("v%0d arvalid", idx), 64'(arvalid), 64'(1));
      check($sformatf("v%0d awvalid", idx), 64'(awvalid), 64'(0));
      check($sformatf("v%0d araddr", idx), 64'(araddr), 64'(v.addr));
      check($sformatf("v%0d arid", idx), 64'(arid), 64'(v.client));
      check($sformatf("v%0d arsize", idx), 64'(arsize), 64'(v.exp_size));
      check($sformatf("v%0d arlen/burst", idx), 64'({arlen, arburst}), 64'({8'd0, 2'b01}));
      arready = 1;
      step();
      arready = 0;
      rvalid = 1; rdata = v.slave_rdata; rresp = v.resp;
      #1;
      check($sformatf("v%0d rready", idx), 64'(rready), 64'(1));
      check($sformatf("v%0d arvalid_drop", idx), 64'(arvalid), 64'(0));
      step();
      rvalid = 0; rdata = '0; rresp = 2'b00;
      #1;
    end else begin
      check($sformatf("v%0d awvalid", idx), 64'(awvalid), 64'(1));
      check($sformatf("v%0d wvalid", idx), 64'(wvalid), 64'(1));
      check($sformatf("v%0d arvalid", idx), 64'(arvalid), 64'(0));
      check($sformatf("v%0d awaddr", idx), 64'(awaddr), 64'(v.addr));
      check($sformatf("v%0d awid", idx), 64'(awid), 64'(v.client));
      check($sformatf("v%0d awsize", idx), 64'(awsize), 64'(v.exp_size));
      check($sformatf("v%0d awlen/burst", idx), 64'({awlen, awburst}), 64'({8'd0, 2'b01}));
      check($sformatf("v%0d wdata", idx), wdata, v.exp_wdata);
      check($sformatf("v%0d wstrb", idx), 64'(wstrb), 64'(v.exp_wstrb));
      check($sformatf("v%0d wlast", idx), 64'(wlast), 64'(1));
      awready = 1; wready = 1;
      step();
      awready = 0; wready = 0;
      bvalid = 1; bresp = v.resp;
      #1;
      check($sformatf("v%0d bready", idx), 64'(bready), 64'(1));
      check($sformatf("v%0d aw/w drop", idx), 64'({awvalid, wvalid}), 64'(0));
      step();
      bvalid = 0; bresp = 2'b00;
      #1;
    end
    check($sformatf("v%0d rsp_valid_t3", idx), 64'(rsp_valid), 64'(oh));
    step();
    #1;
    check($sformatf("v%0d rsp_valid_pulse", idx), 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int grants, fp_grants, exp_g;
    //            cl wr addr           wd            ws     slave rdata            rsp
    //            size wdata                  wstrb  rdata         err
    vecs[0] = '{1, 1'b0, 32'h8000_0004, 32'h0, 4'hf, 64'h11223344_55667788, 2'b00,
                3'd2, 64'h0, 8'h00, 32'h11223344, 1'b0};
    vecs[1] = '{0, 1'b1, 32'h8000_0003, 32'hab, 4'h1, 64'h0, 2'b00,
                3'd0, 64'hab000000_ab000000, 8'h08, 32'h0, 1'b0};
    vecs[2] = '{0, 1'b0, 32'h8000_0000, 32'h0, 4'hf, 64'hdeadbeef_cafef00d, 2'b00,
                3'd2, 64'h0, 8'h00, 32'hcafef00d, 1'b0};
    vecs[3] = '{1, 1'b1, 32'h8000_0006, 32'h1234, 4'h3, 64'h0, 2'b00,
                3'd1, 64'h12340000_12340000, 8'hc0, 32'h0, 1'b0};
    vecs[4] = '{0, 1'b1, 32'h8000_0004, 32'h55aa55aa, 4'hf, 64'h0, 2'b10,
                3'd2, 64'h55aa55aa_55aa55aa, 8'hf0, 32'h0, 1'b1};
    vecs[5] = '{1, 1'b0, 32'h8000_000c, 32'h0, 4'h1, 64'h01020304_05060708, 2'b11,
                3'd0, 64'h0, 8'h00, 32'h01020304, 1'b1};
    vecs[6] = '{1, 1'b1, 32'h8000_0001, 32'h00ff00ff, 4'h5, 64'h0, 2'b00,
                3'd2, 64'hff00ff00_ff00ff00, 8'h0a, 32'h0, 1'b0};
    vecs[7] = '{0, 1'b0, 32'h8000_0002, 32'h0, 4'h3, 64'haaaabbbb_ccccdddd, 2'b00,
                3'd1, 64'h0, 8'h00, 32'hccccdddd, 1'b0};

    rst = 1;
    clear_req();
    clear_slave();
    step();
    step();
    rst = 0;
    #1;
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset valids", 64'({arvalid, awvalid, wvalid}), 64'(0));
    check("reset readies", 64'({rready, bready}), 64'(0));
    check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset rsp_err", 64'(rsp_err), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // AW accepted three cycles before W
    step();
    set_req(0, 1'b1, 32'h8000_0000, 32'h1, 4'hf);
    #1;
    check("split req_ready", 64'(req_ready), 64'(2'b01));
    e.onehot = 2'b01; e.rdata = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_req();
    awready = 1;
    #1;
    check("split aw/w raised", 64'({awvalid, wvalid}), 64'(2'b11));
    step();
    awready = 0;
    #1;
    check("split awvalid drop", 64'(awvalid), 64'(0));
    check("split wvalid hold", 64'(wvalid), 64'(1));
    check("split no bready", 64'(bready), 64'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      check("split wait", 64'({awvalid, wvalid, bready}), 64'(3'b010));
    end
    step();
    wready = 1;
    #1;
    check("split wvalid at wready", 64'(wvalid), 64'(1));
    step();
    wready = 0;
    bvalid = 1;
    #1;
    check("split bready", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    step();
    bvalid = 0;
    #1;
    check("split rsp_valid", 64'(rsp_valid), 64'(2'b01));
    step();
    #1;
    check("split single rsp", 64'(rsp_valid), 64'(0));

    // Round-robin vs fixed priority with both clients requesting from reset
    rst = 1;
    step();
    rst = 0;
    set_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'hf);
    set_req(1, 1'b0, 32'h8000_0004, 32'h0, 4'hf);
    arready = 1; rvalid = 1; rdata = 64'h11223344_55667788; rresp = 2'b00;
    grants = 0; fp_grants = 0; exp_g = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        check($sformatf("rr grant %0d", grants), 64'(req_ready), 64'(2'b01 << exp_g));
        e.onehot = 2'b01 << exp_g;
        e.rdata  = (exp_g == 0) ? 32'h55667788 : 32'h11223344;
        e.err    = 1'b0;
        sb.push_back(e);
        exp_g = 1 - exp_g;
        grants++;
      end
      if (fp_req_ready != 2'b00) begin
        check($sformatf("fp grant %0d", fp_grants), 64'(fp_req_ready), 64'(2'b01));
        fp_grants++;
      end
      if (grants < 4) step();
    end
    check("rr grant count", 64'(grants), 64'(4));
    check("fp grant count", 64'(fp_grants), 64'(4));
    step();
    clear_req();
    step();
    step();
    clear_slave();
    step();

    // Reset while R handshake is pending
    set_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'hf);
    #1;
    check("rst-in-R accept", 64'(req_ready), 64'(2'b01));
    step();
    clear_req();
    arready = 1;
    #1;
    check("rst-in-R arvalid", 64'(arvalid), 64'(1));
    step();
    arready = 0;
    rvalid = 1; rdata = 64'h0;
    rst = 1;
    #1;
    check("rst-in-R rready", 64'(rready), 64'(1));
    step();
    rst = 0;
    #1;
    check("rst-in-R valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'(0));
    check("rst-in-R no rsp", 64'(rsp_valid), 64'(0));
    rvalid = 0;
    set_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'hf);
    set_req(1, 1'b0, 32'h8000_0004, 32'h0, 4'hf);
    #1;
    check("rst-in-R ptr0", 64'(req_ready), 64'(2'b01));
    e.onehot = 2'b01; e.rdata = 32'h5a5a5a5a; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_req();
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = 64'ha5a5a5a5_5a5a5a5a;
    step();
    clear_slave();
    #1;
    check("post-rst rsp_valid", 64'(rsp_valid), 64'(2'b01));
    step();
    step();

    check("sb drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_bus_rr_arbiter.md
Name: ysyx_bus_rr_arbiter

Overview:
Parametrised N-client arbiter that funnels simple single-beat load/store requests from NUM_M clients (IFU, LSU, DMA, ...) onto one AXI4 master port. It is the generalised successor of the fixed IFU/LSU bus arbiter, with these additions: round-robin or fixed-priority grant, registered request capture, byte-lane placement for any BUS_W/DATA_W ratio, independent AW/W handshakes, and per-client error reporting instead of simulation asserts. One transaction is outstanding at a time.

Parameters:
NUM_M, 2, number of clients (>=1); client 0 is the lowest index
ADDR_W, 32, address width
DATA_W, 32, client data width (power of 2, >=8)
BUS_W, 64, AXI data width (power of 2, >=DATA_W)
RR, 1, 1 = round-robin grant; 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_M  per-client request; held until req_ready
req_write  in  NUM_M  1 = store, 0 = load
req_addr  in  NUM_M*ADDR_W  byte address, client i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_M*DATA_W  LSB-justified store data
req_wstrb  in  NUM_M*(DATA_W/8)  LSB-justified byte mask; also sets load size
req_ready  out  NUM_M  one-hot, 1-cycle accept pulse
rsp_valid  out  NUM_M  one-hot, 1-cycle completion pulse
rsp_rdata  out  DATA_W  load data, valid with rsp_valid; 0 for stores
rsp_err  out  1  response error, valid with rsp_valid
io_master_ar{valid,ready,addr,id,len,size,burst}  out/in  AXI4 AR
io_master_r{valid,ready,data,resp,last,id}  in/out  AXI4 R
io_master_aw{valid,ready,addr,id,len,size,burst}  out/in  AXI4 AW
io_master_w{valid,ready,data,strb,last}  out/in  AXI4 W
io_master_b{valid,ready,resp,id}  in/out  AXI4 B

Behaviour:
- Reset: FSM=IDLE; grant pointer=0. All valid, ready and req_ready/rsp_valid outputs are 0. rsp_rdata=0, rsp_err=0. Reset mid-transaction abandons it with no rsp_valid, and all valids drop the next cycle.
- FSM states: IDLE, AR, R, WR, B.
- IDLE: if any req_valid, pick winner g. With RR=1, search from the pointer upward with wrap; with RR=0, take the lowest index. Same cycle: req_ready[g]=1; capture addr, wdata, wstrb, write and g. Next state is WR if write, else AR. With RR=1 the pointer becomes (g+1) mod NUM_M. No request: stay in IDLE.
- AR: arvalid=1 with the registered fields. On arready, go to R.
- R: rready=1. On rvalid: register rdata/rresp, go to IDLE.
- WR: awvalid and wvalid are both raised on entry and each drops independently after its own handshake (done flags). When both are done (same cycle allowed), go to B.
- B: bready=1. On bvalid, go to IDLE.
- Response: rsp_valid[g] pulses the cycle after the R or B handshake, i.e. the first IDLE cycle. A new request may be accepted in that same cycle. rsp_err = (resp != 2'b00).
- Latency with zero-wait slave: accept at T, arvalid T+1, r handshake T+2, rsp_valid T+3.
- AXI fixed fields: arid/awid = g (4 bits, zero-extended); len=0; burst=2'b01; wlast=1.
- size: strb 0x1→0, 0x3→1, 0xF→2, 0xFF→3, else log2(DATA_W/8).
- Lane math: OFF = addr[log2(DATA_W/8)-1:0]; LANE = addr[log2(BUS_W/8)-1:log2(DATA_W/8)].
- Store data: wdata = (req_wdata << 8*OFF) truncated to DATA_W, replicated across all BUS_W/DATA_W lanes.
- Store strobe: wstrb = ((req_wstrb << OFF) truncated) << (LANE*DATA_W/8), all other lanes 0.
- Load data: rsp_rdata = rdata lane LANE, not shifted. When BUS_W == DATA_W there is no lane select.
- rid/bid/rlast are ignored.
- Between request accept and response, the other clients' req_valid is ignored (no req_ready).

Test Plan:
- Load, client 1, addr 0x80000004, strb 0xF; slave rdata 0x11223344_55667788, rresp 0 → arsize 2, arid 1, rsp_valid=2'b10 at T+3, rsp_rdata 0x11223344, rsp_err 0.
- Byte store, client 0, addr 0x80000003, wdata 0xAB, strb 0x1 → awsize 0, wdata 0xAB000000_AB000000, wstrb 0x08, wlast 1.
- awready 3 cycles before wready → awvalid drops after its handshake, wvalid held; B entered only after W done; single rsp_valid.
- RR=1, both clients continuously requesting from reset → grants alternate 0,1,0,1. RR=0 → client 0 always wins.
- bresp=2'b10 on a store → rsp_valid with rsp_err=1; the next transaction proceeds normally.
- rst asserted in R state while rvalid is pending → the cycle after, all valids 0, FSM IDLE, no rsp_valid, pointer 0.
